image_loader: RTL and testbench

- AXI4-Lite slave holding an image buffer of 32-bit words. Software fills and reads back the buffer through the AXI4-Lite port.
- A `start` pulse streams the buffer out on an AXI4-Stream master port (`x_*`) to the neural-net datapath.
- Sits between the PS/AXI interconnect and the first network layer.

---
 rtl/image_loader_pkg.sv | 17 +
 rtl/image_bram.sv | 48 ++++
 rtl/image_loader.sv | 170 +++++++++++++++++
 tb/tb_image_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/image_loader_pkg.sv
// Shared constants for the image loader: buffer geometry, the AXI response
// code, and the encoding of the stream FSM states.
package image_loader_pkg;

    localparam int IL_DEPTH   = 1024;  // buffer depth in 32-bit words
    localparam int IL_N_WORDS = 784;   // words streamed per start (28x28 image)
    localparam int IL_ADDR_W  = 12;    // AXI4-Lite byte address width
    localparam int IL_DATA_W  = 32;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Stream FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

endpackage

// File: rtl/image_bram.sv
// True dual-port synchronous RAM holding the image buffer.
//   clk              : single clock, rising edge
//   a_we[3:0]        : port A byte-lane write enables
//   a_re             : port A read enable; a_dout holds when low
//   a_addr, a_din    : port A word address and write data
//   a_dout           : port A registered read data
//   b_en, b_addr     : port B read enable and word address
//   b_dout           : port B registered read data (holds when b_en is low)
// Contents are not reset.
module image_bram
    import image_loader_pkg::*;
#(
    parameter int DEPTH = IL_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic [3:0]           a_we,
    input  logic                 a_re,
    input  logic [IDX_W-1:0]     a_addr,
    input  logic [IL_DATA_W-1:0] a_din,
    output logic [IL_DATA_W-1:0] a_dout,
    input  logic                 b_en,
    input  logic [IDX_W-1:0]     b_addr,
    output logic [IL_DATA_W-1:0] b_dout
);

    logic [3:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_we[i]) begin
                mem[a_addr][i] <= a_din[8*i +: 8];
            end
        end
        if (a_re) begin
            a_dout <= mem[a_addr];
        end
    end

    // The output register only updates on b_en, so it doubles as the
    // stream's holding register while the consumer stalls.
    always_ff @(posedge clk) begin
        if (b_en) begin
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/image_loader.sv
// AXI4-Lite slave fronting an image buffer, plus an AXI4-Stream master that
// plays N_WORDS buffer words out on each rising edge of start.
//   s_axi_aclk, s_axi_aresetn : clock, asynchronous active-low reset
//   start                     : stream trigger (rising-edge detected)
//   s_axi_aw*/w*/b*           : AXI4-Lite write channels (OKAY only)
//   s_axi_ar*/r*              : AXI4-Lite read channels (OKAY only)
//   x_tdata/x_tvalid/x_tready : AXI4-Stream image output
module image_loader
    import image_loader_pkg::*;
#(
    parameter int DEPTH   = IL_DEPTH,
    parameter int N_WORDS = IL_N_WORDS,
    parameter int ADDR_W  = IL_ADDR_W
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    s_axi_awaddr,
    input  logic [2:0]           s_axi_awprot,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [IL_DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ADDR_W-1:0]    s_axi_araddr,
    input  logic [2:0]           s_axi_arprot,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [IL_DATA_W-1:0] s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic [IL_DATA_W-1:0] x_tdata,
    output logic                 x_tvalid,
    input  logic                 x_tready
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    logic                 awready_reg, bvalid_reg, arready_reg, rvalid_reg;
    logic                 x_tvalid_reg, start_q;
    logic [1:0]           state_reg;
    logic [IDX_W-1:0]     r_addr;
    logic                 aw_accept, ar_accept, w_hs, ar_hs, beat_hs, start_edge;
    logic [3:0]           a_we;
    logic [IDX_W-1:0]     a_addr, b_addr;
    logic                 b_en;
    logic [IL_DATA_W-1:0] a_dout, b_dout;
    logic                 unused_bits;

    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_awprot, s_axi_arprot};

    // ---------------- AXI4-Lite ----------------
    // awready is registered: the decision is taken one cycle ahead and the
    // handshake happens while the master still holds its valids.
    assign aw_accept = s_axi_awvalid & s_axi_wvalid & ~bvalid_reg & ~awready_reg;
    assign w_hs      = awready_reg & s_axi_awvalid & s_axi_wvalid;
    // Port A is shared by both AXI channels; a read is never granted in the
    // cycle a write is granted, so the two handshakes never collide on it.
    assign ar_accept = s_axi_arvalid & ~rvalid_reg & ~arready_reg & ~aw_accept;
    assign ar_hs     = arready_reg & s_axi_arvalid;

    assign a_we   = w_hs ? s_axi_wstrb : 4'b0000;
    assign a_addr = w_hs ? s_axi_awaddr[IDX_W+1:2] : s_axi_araddr[IDX_W+1:2];

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
        end else begin
            awready_reg <= aw_accept;
            arready_reg <= ar_accept;
            if (w_hs) begin
                bvalid_reg <= 1'b1;
            end else if (s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
            end else if (s_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign s_axi_awready = awready_reg;
    assign s_axi_wready  = awready_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = AXI_RESP_OKAY;
    assign s_axi_arready = arready_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rresp   = AXI_RESP_OKAY;
    // a_dout only changes on a read handshake, so it is stable while rvalid waits.
    assign s_axi_rdata   = rvalid_reg ? a_dout : '0;

    // ---------------- Stream ----------------
    assign start_edge = start & ~start_q;
    assign beat_hs    = x_tvalid_reg & x_tready;

    // Port B fetches word 0 on the trigger, then fetches the following word on
    // every accepted beat; the RAM output register holds the current beat.
    assign b_en   = ((state_reg == ST_IDLE) & start_edge) | ((state_reg == ST_STREAM) & beat_hs);
    assign b_addr = (state_reg == ST_IDLE) ? '0 : r_addr + IDX_ONE;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            start_q      <= 1'b0;
            state_reg    <= ST_IDLE;
            r_addr       <= '0;
            x_tvalid_reg <= 1'b0;
        end else begin
            start_q <= start;
            case (state_reg)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_reg <= ST_PRIME;
                        r_addr    <= '0;
                    end
                end
                ST_PRIME: begin
                    state_reg    <= ST_STREAM;
                    x_tvalid_reg <= 1'b1;
                end
                ST_STREAM: begin
                    if (beat_hs) begin
                        if (r_addr == LAST_IDX) begin
                            state_reg    <= ST_IDLE;
                            x_tvalid_reg <= 1'b0;
                            r_addr       <= '0;
                        end else begin
                            r_addr <= r_addr + IDX_ONE;
                        end
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    x_tvalid_reg <= 1'b0;
                    r_addr       <= '0;
                end
            endcase
        end
    end

    assign x_tvalid = x_tvalid_reg;
    assign x_tdata  = x_tvalid_reg ? b_dout : '0;

    image_bram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bram (
        .clk    (s_axi_aclk),
        .a_we   (a_we),
        .a_re   (ar_hs),
        .a_addr (a_addr),
        .a_din  (s_axi_wdata),
        .a_dout (a_dout),
        .b_en   (b_en),
        .b_addr (b_addr),
        .b_dout (b_dout)
    );

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;

    localparam int NW = 784;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        start;
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata, x_tdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        x_tvalid, x_tready;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [1024];
    logic [31:0] rd_q [$];
    logic [31:0] st_q [$];

    always #5 clk = ~clk;

    image_loader dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .start         (start),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .x_tdata       (x_tdata),
        .x_tvalid      (x_tvalid),
        .x_tready      (x_tready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic [31:0] old;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!awready && n < 20);
        chk("aw_wait", 32'(n < 20), 32'd1);
        chk("wready_with_awready", {31'd0, wready}, 32'd1);
        tick();  // handshake edge
        awvalid = 1'b0; wvalid = 1'b0;
        chk("awready_pulse", {30'd0, awready, wready}, 32'd0);
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, 32'd0);
        old = model[a[11:2]];
        for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
        model[a[11:2]] = old;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [11:0] a);
        int n;
        logic [31:0] e, held;
        araddr = a; arvalid = 1'b1;
        rd_q.push_back(model[a[11:2]]);
        n = 0;
        do begin tick(); n++; end while (!arready && n < 20);
        chk("ar_wait", 32'(n < 20), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("arready_pulse", {31'd0, arready}, 32'd0);
        chk("rvalid", {31'd0, rvalid}, 32'd1);
        e = rd_q.pop_front();
        chk($sformatf("rdata@%03h", a), rdata, e);
        chk("rresp", {30'd0, rresp}, 32'd0);
        held = rdata;
        tick();  // rready still low: data must hold
        chk("rdata_hold", rdata, held);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rvalid_clear", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic run_stream(input bit rand_ready, input int restart_at);
        int beats, cycles, gaps, idle_valid;
        bit stalled;
        logic [31:0] prev_data, e;
        for (int i = 0; i < NW; i++) st_q.push_back(model[i]);
        x_tready = 1'b1;
        start = 1'b1;
        tick();
        chk("tvalid_edge+1", {31'd0, x_tvalid}, 32'd0);
        tick();
        chk("tvalid_edge+2", {31'd0, x_tvalid}, 32'd1);
        start = 1'b0;
        beats = 0; cycles = 0; gaps = 0; stalled = 1'b0; prev_data = '0;
        while (beats < NW && cycles < 20000) begin
            if (stalled) begin
                chk("stall_valid", {31'd0, x_tvalid}, 32'd1);
                chk("stall_data", x_tdata, prev_data);
            end
            start = (cycles == restart_at);
            if (rand_ready) x_tready = ($urandom_range(0, 9) < 6);
            if (x_tvalid && x_tready) begin
                e = st_q.pop_front();
                chk($sformatf("beat%0d", beats), x_tdata, e);
                beats++;
                stalled = 1'b0;
            end else if (x_tvalid) begin
                stalled = 1'b1;
                prev_data = x_tdata;
            end else begin
                gaps++;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        x_tready = 1'b1;
        chk("beat_count", beats, NW);
        chk("valid_gaps", gaps, 0);
        chk("queue_empty", st_q.size(), 0);
        chk("tvalid_after_last", {31'd0, x_tvalid}, 32'd0);
        chk("r_addr_after_last", {22'd0, dut.r_addr}, 32'd0);
        idle_valid = 0;
        repeat (8) begin
            tick();
            if (x_tvalid) idle_valid++;
        end
        chk("no_retrigger", idle_valid, 0);
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; x_tready = 1'b0;

        repeat (30) tick();
        chk("rst_ctrl", {21'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, x_tvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_tdata", x_tdata, 32'd0);
        chk("rst_r_addr", {22'd0, dut.r_addr}, 32'd0);
        aresetn = 1'b1;
        tick();
        chk("post_rst_ctrl", {21'd0, awready, wready, bvalid, bresp, arready, rvalid, rresp, x_tvalid}, 32'd0);

        axi_write(12'h000, 32'h0000ABCD, 4'hF);
        axi_write(12'h004, 32'h1111FADE, 4'hF);
        axi_write(12'h008, 32'h2222CAFE, 4'hF);
        axi_write(12'h00C, 32'h3333BABE, 4'hF);
        axi_write(12'h010, 32'h4444FEED, 4'hF);

        for (int i = 4; i >= 0; i--) begin
            repeat ($urandom_range(0, 50)) tick();
            axi_read(12'(i * 4));
        end
        chk("model_w4", model[4], 32'h4444FEED);

        axi_write(12'h000, 32'hFFFFFFFF, 4'b0011);
        axi_read(12'h000);
        chk("model_strobe", model[0], 32'h0000FFFF);
        axi_write(12'h000, 32'h0000ABCD, 4'hF);

        for (int i = 5; i < NW; i++) axi_write(12'(i * 4), {i[15:0], ~i[15:0]}, 4'hF);
        axi_read(12'(700 * 4));

        run_stream(1'b0, -1);
        run_stream(1'b1, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
